// File: rtl/ef_smsdac_pkg.sv
// Shared types, constants and the single-step LFSR function for the mismatch-shaping PRNG.
package ef_smsdac_pkg;

   localparam int unsigned LFSR_W = 23;
   localparam int unsigned TAP_HI = 22;
   localparam int unsigned TAP_LO = 17;
   localparam int unsigned WCNT_W = 4;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 23'h000001;

   typedef enum logic [1:0] {
      WARM = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   typedef struct packed {
      logic [LFSR_W-1:0] s;
      logic              fb;
   } step_t;

   // One Fibonacci step of x^23+x^18+1; the feedback bit is also the output bit.
   function automatic step_t lfsr_step(input logic [LFSR_W-1:0] s);
      step_t o;
      o.fb = s[TAP_HI] ^ s[TAP_LO];
      o.s  = {s[LFSR_W-2:0], o.fb};
      return o;
   endfunction

endpackage

// File: rtl/ef_smsdac_lfsr_leap.sv
// Combinational NOUT-step leap-forward of the shared LFSR; bits[i] is the feedback of step i+1.
module ef_smsdac_lfsr_leap
   import ef_smsdac_pkg::*;
#(
   parameter int unsigned NOUT = 7
) (
   input  logic [LFSR_W-1:0] s,
   output logic [LFSR_W-1:0] s_next,
   output logic [NOUT-1:0]   bits
);

   always_comb begin
      step_t st;
      st.s  = s;
      st.fb = 1'b0;
      bits  = '0;
      for (int i = 0; i < int'(NOUT); i++) begin
         st      = lfsr_step(st.s);
         bits[i] = st.fb;
      end
      s_next = st.s;
   end

endmodule

// File: rtl/ef_smsdac_prng.sv
// PRNG feeding the switching-block r inputs: warm-up/run/hold FSM, seed handshake, lock-up recovery.
// Optional r[0] ones-count statistics are built when EF_SMSDAC_PRNG_STATS_EN is defined.
module ef_smsdac_prng
   import ef_smsdac_pkg::*;
#(
   parameter int unsigned NOUT     = 7,
   parameter int unsigned WARM_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [LFSR_W-1:0] seed,
   input  logic              seed_valid,
   output logic              seed_ready,
   output logic [NOUT-1:0]   r,
   output logic              r_valid,
   output logic              lockup
`ifdef EF_SMSDAC_PRNG_STATS_EN
   ,
   output logic [7:0]        ones_cnt,
   output logic              stats_done
`endif
);

   // With no warm-up the block leaves reset already in RUN.
   localparam state_e RST_ST = (WARM_CYC == 0) ? RUN : WARM;

   state_e              state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [LFSR_W-1:0]   leap_s;
   logic [NOUT-1:0]     leap_bits;
   logic [NOUT-1:0]     r_d;
   logic                r_valid_d;
   logic                lockup_d;
   logic                seed_ready_d;
   logic                load;
   state_e              exit_st;

   ef_smsdac_lfsr_leap #(.NOUT(NOUT)) u_leap (
      .s      (lfsr_q),
      .s_next (leap_s),
      .bits   (leap_bits)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RST_ST;
         wcnt_q     <= '0;
         lfsr_q     <= DEFAULT_SEED;
         r          <= '0;
         r_valid    <= 1'b0;
         lockup     <= 1'b0;
         seed_ready <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         lfsr_q     <= lfsr_d;
         r          <= r_d;
         r_valid    <= r_valid_d;
         lockup     <= lockup_d;
         seed_ready <= seed_ready_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      lfsr_d       = lfsr_q;
      r_d          = '0;
      r_valid_d    = 1'b0;
      lockup_d     = lockup;
      load         = seed_valid & seed_ready;
      exit_st      = run ? RUN : HOLD;

      case (state_q)
         WARM: begin
            lfsr_d = leap_s;
            if (32'(wcnt_q) + 32'd1 >= WARM_CYC) begin
               state_d = exit_st;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         RUN: begin
            if (run) begin
               lfsr_d    = leap_s;
               r_d       = leap_bits;
               r_valid_d = 1'b1;
            end else begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (run) state_d = RUN;
         end
         default: begin
            state_d = WARM;
            wcnt_d  = '0;
         end
      endcase

      // A seed transfer overrides the step; run is re-evaluated when WARM ends.
      if (load) begin
         lfsr_d    = (seed == '0) ? DEFAULT_SEED : seed;
         state_d   = (WARM_CYC == 0) ? exit_st : WARM;
         wcnt_d    = '0;
         r_d       = '0;
         r_valid_d = 1'b0;
      end else if (lfsr_q == '0) begin
         lfsr_d = DEFAULT_SEED;
      end

      if (lfsr_q == '0) lockup_d = 1'b1;

      seed_ready_d = (state_d != WARM);
   end

`ifdef EF_SMSDAC_PRNG_STATS_EN
   logic [7:0] win_q;
   logic [7:0] ones_q;

   // Ones on r[0] over 255 valid samples; the window restarts on reset or seed load.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         win_q      <= '0;
         ones_q     <= '0;
         stats_done <= 1'b0;
         if (rst) ones_cnt <= '0;
      end else begin
         stats_done <= 1'b0;
         if (r_valid) begin
            if (win_q == 8'd254) begin
               ones_cnt   <= ones_q + 8'(r[0]);
               stats_done <= 1'b1;
               win_q      <= '0;
               ones_q     <= '0;
            end else begin
               win_q  <= win_q + 8'd1;
               ones_q <= ones_q + 8'(r[0]);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_ef_smsdac_prng.sv
// Self-checking bench for ef_smsdac_prng against a bit-recurrence model of the LFSR sequence.
module tb_ef_smsdac_prng;
   import ef_smsdac_pkg::*;

   localparam int unsigned NOUT = 7;
   localparam int HOLDM = 0;
   localparam int WARMM = 1;
   localparam int RUNM  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              run;
   logic [LFSR_W-1:0] seed;
   logic              seed_valid;
   logic              seed_ready, seed_ready0;
   logic [NOUT-1:0]   r, r0;
   logic              r_valid, r_valid0;
   logic              lockup, lockup0;
`ifdef EF_SMSDAC_PRNG_STATS_EN
   logic [7:0]        ones_cnt, ones_cnt0;
   logic              stats_done, stats_done0;
`endif

   int errs   = 0;
   int checks = 0;

   bit              hist[$];
   bit              hsave[$];
   logic [NOUT-1:0] last_w;
   logic [NOUT-1:0] e0;
   logic [LFSR_W-1:0] sa, sb;
   bit              in_run;
   int              ones;

   always #5 clk = ~clk;

   ef_smsdac_prng #(.NOUT(NOUT), .WARM_CYC(2)) dut (
      .clk(clk), .rst(rst), .run(run), .seed(seed), .seed_valid(seed_valid),
      .seed_ready(seed_ready), .r(r), .r_valid(r_valid), .lockup(lockup)
`ifdef EF_SMSDAC_PRNG_STATS_EN
      , .ones_cnt(ones_cnt), .stats_done(stats_done)
`endif
   );

   ef_smsdac_prng #(.NOUT(NOUT), .WARM_CYC(0)) dut0 (
      .clk(clk), .rst(rst), .run(run), .seed(seed), .seed_valid(seed_valid),
      .seed_ready(seed_ready0), .r(r0), .r_valid(r_valid0), .lockup(lockup0)
`ifdef EF_SMSDAC_PRNG_STATS_EN
      , .ones_cnt(ones_cnt0), .stats_done(stats_done0)
`endif
   );

   // Sequence model: history of the last 23 emitted bits, b[n] = b[n-23] ^ b[n-18].
   function automatic void model_load(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] v;
      v = (s == '0) ? DEFAULT_SEED : s;
      hist.delete();
      for (int k = int'(LFSR_W) - 1; k >= 0; k--) hist.push_back(v[k]);
   endfunction

   function automatic bit model_bit();
      bit b;
      b = hist[0] ^ hist[5];
      void'(hist.pop_front());
      hist.push_back(b);
      return b;
   endfunction

   function automatic logic [NOUT-1:0] model_word();
      logic [NOUT-1:0] w;
      for (int i = 0; i < int'(NOUT); i++) w[i] = model_bit();
      return w;
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_r(input string tag, input logic [NOUT-1:0] er, input logic ev);
      checks++;
      assert (r === er) else begin
         errs++;
         $error("FAIL %s r observed=%b expected=%b", tag, r, er);
      end
      chk1({tag, "_valid"}, r_valid, ev);
   endtask

   task automatic tick(input string tag, input int mode);
      logic [NOUT-1:0] w;
      @(posedge clk); #1;
      case (mode)
         WARMM: begin
            w = model_word();
            chk_r(tag, '0, 1'b0);
         end
         RUNM: begin
            w = model_word();
            last_w = w;
            chk_r(tag, w, 1'b1);
         end
         default: chk_r(tag, '0, 1'b0);
      endcase
   endtask

   task automatic tick_load(input string tag, input logic [LFSR_W-1:0] s);
      @(posedge clk); #1;
      model_load(s);
      chk_r(tag, '0, 1'b0);
      chk1({tag, "_ready"}, seed_ready, 1'b0);
   endtask

   initial begin
      rst = 1'b1; run = 1'b1; seed_valid = 1'b0; seed = '0; last_w = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_r("reset", '0, 1'b0);
      chk1("reset_ready", seed_ready, 1'b0);
      chk1("reset_lockup", lockup, 1'b0);

      // Warm-up flush then free run from DEFAULT_SEED.
      model_load(DEFAULT_SEED);
      rst = 1'b0;
      tick("warm1", WARMM);
      chk1("warm1_ready", seed_ready, 1'b0);
      tick("warm2", WARMM);
      chk1("warm2_ready", seed_ready, 1'b1);
      for (int i = 0; i < 20; i++) tick("run", RUNM);

      // Random run/hold pattern.
      in_run = 1'b1;
      for (int i = 0; i < 40; i++) begin
         run = ($urandom_range(0, 3) != 0);
         tick("rand_run", (in_run && run) ? RUNM : HOLDM);
         in_run = run;
      end
      run = 1'b1;
      tick("settle", in_run ? RUNM : HOLDM);
      tick("settle2", RUNM);

      // Five-cycle gap must resume the sequence seamlessly.
      run = 1'b0;
      for (int i = 0; i < 5; i++) tick("gap", HOLDM);
      run = 1'b1;
      tick("resume_edge", HOLDM);
      for (int i = 0; i < 10; i++) tick("resume", RUNM);

      // Seed load with seed_valid held through WARM; second transfer waits for ready.
      sa = LFSR_W'($urandom) | LFSR_W'(1);
      sb = LFSR_W'($urandom) | LFSR_W'(2);
      seed = sa; seed_valid = 1'b1;
      tick_load("load_a", sa);
      seed = sb;
      tick("held_w1", WARMM);
      chk1("held_w1_ready", seed_ready, 1'b0);
      tick("held_w2", WARMM);
      chk1("held_w2_ready", seed_ready, 1'b1);
      tick_load("load_b", sb);
      seed_valid = 1'b0;
      tick("b_w1", WARMM);
      tick("b_w2", WARMM);
      for (int i = 0; i < 10; i++) tick("b_run", RUNM);

      // Zero seed behaves as DEFAULT_SEED without raising lockup.
      seed = '0; seed_valid = 1'b1;
      tick_load("load_zero", '0);
      seed_valid = 1'b0;
      tick("z_w1", WARMM);
      tick("z_w2", WARMM);
      for (int i = 0; i < 10; i++) tick("z_run", RUNM);
      chk1("z_lockup", lockup, 1'b0);

      // No-warm-up instance: valid r one edge after the load edge.
      chk1("w0_ready", seed_ready0, 1'b1);
      seed = 23'h020000; seed_valid = 1'b1;
      tick_load("load_w0", 23'h020000);
      chk1("w0_load_valid", r_valid0, 1'b0);
      seed_valid = 1'b0;
      hsave = hist;
      e0 = model_word();
      hist = hsave;
      tick("w0_main_w1", WARMM);
      checks++;
      assert (r0 === e0) else begin
         errs++;
         $error("FAIL w0_first r observed=%b expected=%b", r0, e0);
      end
      chk1("w0_first_valid", r_valid0, 1'b1);
      chk1("w0_lockup", lockup0, 1'b0);
      tick("w0_main_w2", WARMM);
      for (int i = 0; i < 5; i++) tick("w0_main_run", RUNM);

      // Lock-up recovery from a forced all-zero state while held.
      run = 1'b0;
      tick("lk_hold", HOLDM);
      tick("lk_hold2", HOLDM);
      chk1("lk_pre", lockup, 1'b0);
      dut.lfsr_q <= '0;
      @(posedge clk); #1;
      checks++;
      assert (dut.lfsr_q === DEFAULT_SEED) else begin
         errs++;
         $error("FAIL lk_reload lfsr observed=%h expected=%h", dut.lfsr_q, DEFAULT_SEED);
      end
      chk1("lk_flag", lockup, 1'b1);
      model_load(DEFAULT_SEED);
      run = 1'b1;
      tick("lk_resume_edge", HOLDM);
      for (int i = 0; i < 10; i++) tick("lk_run", RUNM);
      chk1("lk_sticky", lockup, 1'b1);

      // Reset clears the sticky flag and returns to warm-up.
      rst = 1'b1;
      @(posedge clk); #1;
      chk1("rst2_lockup", lockup, 1'b0);
      chk1("rst2_valid", r_valid, 1'b0);
      chk1("rst2_ready", seed_ready, 1'b0);
      rst = 1'b0;
      model_load(DEFAULT_SEED);

`ifdef EF_SMSDAC_PRNG_STATS_EN
      tick("st_w1", WARMM);
      tick("st_w2", WARMM);
      ones = 0;
      for (int i = 0; i < 255; i++) begin
         tick("st_run", RUNM);
         ones += int'(last_w[0]);
      end
      tick("st_last", RUNM);
      chk1("st_done", stats_done, 1'b1);
      checks++;
      assert (int'(ones_cnt) === ones) else begin
         errs++;
         $error("FAIL st_ones observed=%0d expected=%0d", ones_cnt, ones);
      end
      chk1("st_range", (ones_cnt >= 8'd96) && (ones_cnt <= 8'd160), 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
